vga_rect_fill: RTL and testbench

//  Bus-mapped rectangle fill engine, upstream of the VGA frame buffer write port (port A, 160x120, 1 bit/pixel).
//  The CPU writes two corners, a colour and a start bit. The block then streams one pixel write per clock to the frame buffer until the rectangle is filled.

---
 rtl/vga_rect_fill.sv | 144 ++++++++++++++
 tb/tb_vga_rect_fill.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_rect_fill.sv
// ============================================================================
// Module  : vga_rect_fill
// Brief   : Bus-mapped rectangle fill engine streaming one pixel per clock
//           into the 160x120 1-bpp frame buffer write port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vga_rect_fill #(
  parameter logic [7:0] BASE_ADDR = 8'hB4,
  parameter int         H_PIXELS  = 160,
  parameter int         V_PIXELS  = 120
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  bus_addr_i,
  input  logic [7:0]  bus_data_i,
  input  logic        bus_we_i,
  output logic [7:0]  bus_data_o,
  output logic        bus_data_oe_o,
  output logic [14:0] fb_addr_o,
  output logic        fb_data_o,
  output logic        fb_we_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam logic [7:0] X_LIM = 8'(H_PIXELS - 1);
  localparam logic [6:0] Y_LIM = 7'(V_PIXELS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CLIP = 2'd1,
    S_FILL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t     state_q;
  logic [7:0] x0_q, x1_q;
  logic [6:0] y0_q, y1_q;
  logic       colour_q;
  logic [7:0] xmin_q, xmax_q, x_q;
  logic [6:0] ymax_q, y_q;
  logic       fb_we_q, busy_q, done_q;

  logic [7:0] w_xmin_d, w_xhi, w_xmax_d;
  logic [6:0] w_ymin_d, w_yhi, w_ymax_d;
  logic       w_empty;

  // Bounds are normalised and clamped from the corner registers; only latched in CLIP.
  always_comb begin
    w_xmin_d = (x0_q < x1_q) ? x0_q : x1_q;
    w_xhi    = (x0_q < x1_q) ? x1_q : x0_q;
    w_xmax_d = (w_xhi > X_LIM) ? X_LIM : w_xhi;
    w_ymin_d = (y0_q < y1_q) ? y0_q : y1_q;
    w_yhi    = (y0_q < y1_q) ? y1_q : y0_q;
    w_ymax_d = (w_yhi > Y_LIM) ? Y_LIM : w_yhi;
    w_empty  = (w_xmin_d > X_LIM) || (w_ymin_d > Y_LIM);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      x0_q     <= '0;
      x1_q     <= '0;
      y0_q     <= '0;
      y1_q     <= '0;
      colour_q <= 1'b0;
      xmin_q   <= '0;
      xmax_q   <= '0;
      ymax_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      fb_we_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus_we_i) begin
            if (bus_addr_i == BASE_ADDR)        x0_q <= bus_data_i;
            if (bus_addr_i == BASE_ADDR + 8'd1) y0_q <= bus_data_i[6:0];
            if (bus_addr_i == BASE_ADDR + 8'd2) x1_q <= bus_data_i;
            if (bus_addr_i == BASE_ADDR + 8'd3) y1_q <= bus_data_i[6:0];
            if (bus_addr_i == BASE_ADDR + 8'd4) begin
              colour_q <= bus_data_i[0];
              if (bus_data_i[1]) begin
                busy_q  <= 1'b1;
                state_q <= S_CLIP;
              end
            end
          end
        end
        S_CLIP: begin
          if (w_empty) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            xmin_q  <= w_xmin_d;
            xmax_q  <= w_xmax_d;
            ymax_q  <= w_ymax_d;
            x_q     <= w_xmin_d;
            y_q     <= w_ymin_d;
            fb_we_q <= 1'b1;
            state_q <= S_FILL;
          end
        end
        S_FILL: begin
          if (x_q == xmax_q) begin
            x_q <= xmin_q;
            // Hold y on the final row so the counter never steps past the clamp.
            if (y_q == ymax_q) begin
              fb_we_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              y_q <= y_q + 7'd1;
            end
          end else begin
            x_q <= x_q + 8'd1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fb_addr_o     = {y_q, x_q};
  assign fb_data_o     = colour_q;
  assign fb_we_o       = fb_we_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign bus_data_o    = {7'b0, busy_q};
  assign bus_data_oe_o = (bus_addr_i == BASE_ADDR + 8'd5) & ~bus_we_i;

endmodule

`default_nettype wire

// File: tb/tb_vga_rect_fill.sv
// ============================================================================
// Module  : tb_vga_rect_fill
// Brief   : Randomised self-checking bench for vga_rect_fill against a
//           cycle-timeline reference model built from the fill rules.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_vga_rect_fill;

  localparam logic [7:0] BASE = 8'hB4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  bus_addr = 8'h00;
  logic [7:0]  bus_din = 8'h00;
  logic        bus_we = 1'b0;
  logic [7:0]  bus_dout;
  logic        bus_oe;
  logic [14:0] fb_addr;
  logic        fb_data;
  logic        fb_we;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  vga_rect_fill dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .bus_addr_i   (bus_addr),
    .bus_data_i   (bus_din),
    .bus_we_i     (bus_we),
    .bus_data_o   (bus_dout),
    .bus_data_oe_o(bus_oe),
    .fb_addr_o    (fb_addr),
    .fb_data_o    (fb_data),
    .fb_we_o      (fb_we),
    .busy_o       (busy),
    .done_o       (done)
  );

  typedef struct packed {
    logic        we;
    logic [14:0] addr;
    logic        data;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t exp_q[$];

  int   checks = 0;
  int   errors = 0;
  logic exp_busy_cur = 1'b0;
  int   start_id = 0;
  int   seen_id = 0;
  int   cyc = 0;
  int   wr_count = 0;
  int   done_cyc = 0;
  int   busy_cyc = 0;
  logic [14:0] first_addr = '0;
  logic [14:0] last_addr = '0;

  // Model copy of the programmable registers
  int   mx0 = 0, my0 = 0, mx1 = 0, my1 = 0;
  logic mcol = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, expv, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired at t=%0t", name, $time);
  endtask

  // Expected per-cycle timeline of one fill, starting with the cycle after the start edge.
  task automatic push_fill();
    int   xmin, xmax, ymin, ymax;
    exp_t e;
    xmin = (mx0 < mx1) ? mx0 : mx1;
    xmax = (mx0 > mx1) ? mx0 : mx1;
    ymin = (my0 < my1) ? my0 : my1;
    ymax = (my0 > my1) ? my0 : my1;
    if (xmax > 159) xmax = 159;
    if (ymax > 119) ymax = 119;
    e = '{we: 1'b0, addr: 15'd0, data: 1'b0, busy: 1'b1, done: 1'b0};
    exp_q.push_back(e);
    if (xmin <= 159 && ymin <= 119) begin
      for (int y = ymin; y <= ymax; y++) begin
        for (int x = xmin; x <= xmax; x++) begin
          e = '{we: 1'b1, addr: {7'(y), 8'(x)}, data: mcol, busy: 1'b1, done: 1'b0};
          exp_q.push_back(e);
        end
      end
    end
    e = '{we: 1'b0, addr: 15'd0, data: 1'b0, busy: 1'b1, done: 1'b1};
    exp_q.push_back(e);
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    int off;
    bus_addr = a;
    bus_din  = d;
    bus_we   = 1'b1;
    @(posedge clk);
    off = int'(a) - int'(BASE);
    if (!exp_busy_cur) begin
      case (off)
        0: mx0 = int'(d);
        1: my0 = int'(d & 8'h7F);
        2: mx1 = int'(d);
        3: my1 = int'(d & 8'h7F);
        4: begin
          mcol = d[0];
          if (d[1]) begin
            push_fill();
            start_id++;
          end
        end
        default: ;
      endcase
    end
    #1;
    bus_we   = 1'b0;
    bus_addr = BASE + 8'd5;
    bus_din  = 8'h00;
  endtask

  task automatic program_rect(input int x0, input int y0, input int x1, input int y1, input logic col);
    bus_write(BASE + 8'd0, 8'(x0));
    bus_write(BASE + 8'd1, 8'(y0));
    bus_write(BASE + 8'd2, 8'(x1));
    bus_write(BASE + 8'd3, 8'(y1));
    bus_write(BASE + 8'd4, {6'b0, 1'b1, col});
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || exp_busy_cur) && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (n >= budget) timeout_fail("wait_idle");
    #1;
  endtask

  task automatic wait_pixels(input int count, input int budget);
    int k = 0;
    @(negedge clk);
    #1;
    while (wr_count < count && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (k >= budget) timeout_fail("wait_pixels");
  endtask

  // Single compare process: every cycle against the model timeline.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
      exp_busy_cur = 1'b0;
    end else begin
      if (start_id != seen_id) begin
        seen_id  = start_id;
        cyc      = 0;
        wr_count = 0;
        done_cyc = 0;
        busy_cyc = 0;
      end
      cyc++;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = '{we: 1'b0, addr: 15'd0, data: 1'b0, busy: 1'b0, done: 1'b0};
      exp_busy_cur = e.busy;
      chk("fb_we", fb_we, e.we);
      chk("busy", busy, e.busy);
      chk("done", done, e.done);
      if (e.we) begin
        chk("fb_addr", fb_addr, e.addr);
        chk("fb_data", fb_data, e.data);
      end
      chk("bus_oe", bus_oe, (bus_addr == BASE + 8'd5) && !bus_we);
      chk("bus_dout", bus_dout, {7'b0, e.busy});
      if (fb_we) begin
        if (wr_count == 0) first_addr = fb_addr;
        last_addr = fb_addr;
        wr_count++;
      end
      if (done) done_cyc = cyc;
      if (busy) busy_cyc++;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc;
    int x0, x1, y0, y1;
    rst = 1'b1;
    bus_addr = BASE + 8'd5;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fb_we", fb_we, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_fb_addr", fb_addr, 15'd0);
    chk("rst_status", bus_dout, 8'h00);
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Full-screen clear
    program_rect(0, 0, 159, 119, 1'b1);
    wait_idle(25000);
    chk("clear_count", wr_count, 19200);
    chk("clear_done_cyc", done_cyc, 19202);
    chk("clear_first", first_addr, 15'h0000);
    chk("clear_last", last_addr, 15'h779F);

    // Swapped corners
    program_rect(10, 5, 7, 3, 1'b0);
    wait_idle(200);
    chk("swap_count", wr_count, 12);
    chk("swap_first", first_addr, 15'h0307);
    chk("swap_last", last_addr, 15'h050A);
    chk("swap_busy_cyc", busy_cyc, 14);

    // Clipping at the right/bottom edge
    program_rect(150, 110, 255, 127, 1'b1);
    wait_idle(500);
    chk("clip_count", wr_count, 100);
    chk("clip_first", first_addr, 15'h6E96);
    chk("clip_last", last_addr, 15'h779F);

    // Fully off-screen
    program_rect(200, 0, 200, 0, 1'b1);
    wait_idle(50);
    chk("off_count", wr_count, 0);
    chk("off_done_cyc", done_cyc, 2);
    chk("off_busy_cyc", busy_cyc, 2);

    // Writes during a fill are ignored
    program_rect(20, 30, 39, 49, 1'b1);
    wait_pixels(50, 200);
    chk("status_busy", bus_dout, 8'h01);
    chk("status_oe", bus_oe, 1'b1);
    bus_write(BASE + 8'd2, 8'd0);
    bus_write(BASE + 8'd4, 8'h03);
    wait_idle(1000);
    chk("busy_prot_count", wr_count, 400);
    chk("status_idle", bus_dout, 8'h00);

    // Asynchronous reset mid-fill
    program_rect(0, 0, 39, 9, 1'b1);
    wait_pixels(30, 200);
    chk("pre_rst_we", fb_we, 1'b1);
    #2 rst = 1'b1;
    mx0 = 0; my0 = 0; mx1 = 0; my1 = 0; mcol = 1'b0;
    #1;
    chk("async_rst_we", fb_we, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_done", done, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    wc = wr_count;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_no_writes", wr_count, wc);
    chk("post_rst_busy", busy, 1'b0);

    // Randomised rectangles with colour-only writes and writes while busy
    for (int t = 0; t < 12; t++) begin
      x0 = int'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) x1 = int'($urandom_range(0, 255));
      else begin
        x1 = x0 + int'($urandom_range(0, 24)) - 12;
        if (x1 < 0) x1 = 0;
        if (x1 > 255) x1 = 255;
      end
      y0 = int'($urandom_range(0, 127));
      y1 = y0 + int'($urandom_range(0, 16)) - 8;
      if (y1 < 0) y1 = 0;
      if (y1 > 127) y1 = 127;
      if ($urandom_range(0, 1) == 1) bus_write(BASE + 8'd4, 8'($urandom_range(0, 1)));
      program_rect(x0, y0, x1, y1, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(1, 8)) @(posedge clk);
      #1;
      bus_write(BASE + 8'($urandom_range(0, 4)), 8'($urandom_range(0, 255)));
      wait_idle(5000);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
